control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/minisrc_pkg.sv | 90 +++++++++
 rtl/op_decode.sv | 40 ++++
 rtl/control_unit.sv | 174 +++++++++++++++++
 tb/tb_control_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
// minisrc_pkg
// Shared definitions for the Mini SRC control unit:
//   - state_t     : controller states (RST, T0..T7, HALT)
//   - OP_*        : 5-bit opcode constants found in IR[31:27]
//   - op_class_t  : one-hot instruction-class flags produced by op_decode
//   - last_step() : final timing step of each instruction class
package minisrc_pkg;

    // T0..T7 are kept contiguous so the sequencer can advance by +1.
    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Exactly one flag is set for any opcode; undefined opcodes map to nop.
    typedef struct packed {
        logic ld;
        logic ldi;
        logic st;
        logic alu_rr;
        logic alu_imm;
        logic mul_div;
        logic neg_not;
        logic br;
        logic jr;
        logic jal;
        logic in_port;
        logic out_port;
        logic mfhi;
        logic mflo;
        logic halt;
        logic nop;
    } op_class_t;

    // Step after which the instruction is complete (nop/halt end after fetch).
    function automatic state_t last_step(input op_class_t c);
        state_t s;
        if (c.ld)
            s = ST_T7;
        else if (c.st || c.mul_div || c.br)
            s = ST_T6;
        else if (c.alu_rr || c.alu_imm || c.ldi)
            s = ST_T5;
        else if (c.neg_not || c.jal)
            s = ST_T4;
        else if (c.jr || c.in_port || c.out_port || c.mfhi || c.mflo)
            s = ST_T3;
        else
            s = ST_T2;
        return s;
    endfunction

endpackage

// File: rtl/op_decode.sv
// op_decode
// Maps the 5-bit opcode to one-hot instruction-class flags.
// Ports:
//   opcode   in  5   IR[31:27]
//   op_class out     op_class_t, exactly one flag set
module op_decode
    import minisrc_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        case (opcode)
            OP_LD:   op_class.ld = 1'b1;
            OP_LDI:  op_class.ldi = 1'b1;
            OP_ST:   op_class.st = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:
                     op_class.alu_rr = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:
                     op_class.alu_imm = 1'b1;
            OP_DIV, OP_MUL:
                     op_class.mul_div = 1'b1;
            OP_NEG, OP_NOT:
                     op_class.neg_not = 1'b1;
            OP_BR:   op_class.br = 1'b1;
            OP_JR:   op_class.jr = 1'b1;
            OP_JAL:  op_class.jal = 1'b1;
            OP_IN:   op_class.in_port = 1'b1;
            OP_OUT:  op_class.out_port = 1'b1;
            OP_MFHI: op_class.mfhi = 1'b1;
            OP_MFLO: op_class.mflo = 1'b1;
            OP_HALT: op_class.halt = 1'b1;
            default: op_class.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Hardwired Mini SRC sequencer: fetch T0..T2, execute T3..T7, HALT.
// Ports:
//   Clock, Clear (async active-low), IR[31:0], BranchOut, Stop  inputs
//   Run                            1 while executing
//   PCout..Rout                    bus-driver selects (at most one active)
//   PCin..OutPortIn                register load enables
//   Gra, Grb, Grc                  register-field selects
//   Read, Write, IncPC             memory strobes / PC increment
//   ADD..NOT                       ALU operation strobes
// All outputs decode combinationally from the registered state and opcode.
module control_unit
    import minisrc_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        BranchOut,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout,
    output logic        InPortout, Cout, BAout, Rout,
    output logic        PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin,
    output logic        Rin, CONin, OutPortIn,
    output logic        Gra, Grb, Grc,
    output logic        Read, Write, IncPC,
    output logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL,
    output logic        MUL, DIV, NEG, NOT
);

    state_t     state;
    state_t     next_state;
    op_class_t  op_class;
    logic [4:0] opcode;
    logic       op_strobe;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    op_decode u_op_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // Stop is only consulted on the edge leaving an instruction's final
    // step; halt always parks the machine once fetch completes.
    always_comb begin
        next_state = state;
        case (state)
            ST_RST:  next_state = ST_T0;
            ST_HALT: next_state = ST_HALT;
            default: begin
                if (state == last_step(op_class))
                    next_state = (op_class.halt || Stop) ? ST_HALT : ST_T0;
                else
                    next_state = state_t'(state + 4'd1);
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear)
            state <= ST_RST;
        else
            state <= next_state;
    end

    assign Run = (state != ST_RST) && (state != ST_HALT);

    // op_strobe marks the step in which the instruction's own ALU operation
    // fires; the opcode then selects which strobe is raised.
    always_comb begin
        {PCout, Zlowout, Zhighout, MDRout, LOout, HIout, InPortout, Cout,
         BAout, Rout, PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, Rin,
         CONin, OutPortIn, Gra, Grb, Grc, Read, Write, IncPC, ADD, SUB, AND,
         OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT} = '0;
        op_strobe = 1'b0;
        case (state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                if (op_class.alu_rr || op_class.alu_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (op_class.ldi || op_class.ld || op_class.st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (op_class.mul_div) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (op_class.neg_not) begin
                    Grb = 1'b1; Rout = 1'b1; op_strobe = 1'b1; Zin = 1'b1;
                end else if (op_class.br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (op_class.jr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (op_class.jal) begin
                    PCout = 1'b1; Grb = 1'b1; Rin = 1'b1;
                end else if (op_class.in_port) begin
                    InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op_class.out_port) begin
                    Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
                end else if (op_class.mfhi) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op_class.mflo) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            ST_T4: begin
                if (op_class.alu_rr) begin
                    Grc = 1'b1; Rout = 1'b1; op_strobe = 1'b1; Zin = 1'b1;
                end else if (op_class.alu_imm) begin
                    Cout = 1'b1; op_strobe = 1'b1; Zin = 1'b1;
                end else if (op_class.ldi || op_class.ld || op_class.st) begin
                    Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                end else if (op_class.mul_div) begin
                    Grb = 1'b1; Rout = 1'b1; op_strobe = 1'b1; Zin = 1'b1;
                end else if (op_class.neg_not) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op_class.br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (op_class.jal) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end
            end
            ST_T5: begin
                if (op_class.alu_rr || op_class.alu_imm || op_class.ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op_class.ld || op_class.st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (op_class.mul_div) begin
                    Zlowout = 1'b1; LOin = 1'b1;
                end else if (op_class.br) begin
                    Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                end
            end
            ST_T6: begin
                if (op_class.ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (op_class.st) begin
                    Gra = 1'b1; Rout = 1'b1; Write = 1'b1;
                end else if (op_class.mul_div) begin
                    Zhighout = 1'b1; HIin = 1'b1;
                end else if (op_class.br) begin
                    Zlowout = 1'b1; PCin = BranchOut;
                end
            end
            ST_T7: begin
                if (op_class.ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            default: ;
        endcase
        if (op_strobe) begin
            case (opcode)
                OP_ADD, OP_ADDI: ADD  = 1'b1;
                OP_SUB:          SUB  = 1'b1;
                OP_AND, OP_ANDI: AND  = 1'b1;
                OP_OR, OP_ORI:   OR   = 1'b1;
                OP_SHR:          SHR  = 1'b1;
                OP_SHRA:         SHRA = 1'b1;
                OP_SHL:          SHL  = 1'b1;
                OP_ROR:          ROR  = 1'b1;
                OP_ROL:          ROL  = 1'b1;
                OP_MUL:          MUL  = 1'b1;
                OP_DIV:          DIV  = 1'b1;
                OP_NEG:          NEG  = 1'b1;
                OP_NOT:          NOT  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Scoreboard bench for control_unit: stimulus pushes the expected per-cycle
// output vector of each instruction (from a mnemonic-level microprogram
// table) and a negedge monitor pops and compares.
module tb_control_unit;

    typedef logic [40:0] vec_t;
    typedef vec_t vec_q_t[$];

    localparam vec_t M_PCOUT     = 41'd1 << 0;
    localparam vec_t M_ZLOWOUT   = 41'd1 << 1;
    localparam vec_t M_ZHIGHOUT  = 41'd1 << 2;
    localparam vec_t M_MDROUT    = 41'd1 << 3;
    localparam vec_t M_LOOUT     = 41'd1 << 4;
    localparam vec_t M_HIOUT     = 41'd1 << 5;
    localparam vec_t M_INPORTOUT = 41'd1 << 6;
    localparam vec_t M_COUT      = 41'd1 << 7;
    localparam vec_t M_BAOUT     = 41'd1 << 8;
    localparam vec_t M_ROUT      = 41'd1 << 9;
    localparam vec_t M_PCIN      = 41'd1 << 10;
    localparam vec_t M_IRIN      = 41'd1 << 11;
    localparam vec_t M_MARIN     = 41'd1 << 12;
    localparam vec_t M_MDRIN     = 41'd1 << 13;
    localparam vec_t M_YIN       = 41'd1 << 14;
    localparam vec_t M_ZIN       = 41'd1 << 15;
    localparam vec_t M_LOIN      = 41'd1 << 16;
    localparam vec_t M_HIIN      = 41'd1 << 17;
    localparam vec_t M_RIN       = 41'd1 << 18;
    localparam vec_t M_CONIN     = 41'd1 << 19;
    localparam vec_t M_OUTPORTIN = 41'd1 << 20;
    localparam vec_t M_GRA       = 41'd1 << 21;
    localparam vec_t M_GRB       = 41'd1 << 22;
    localparam vec_t M_GRC       = 41'd1 << 23;
    localparam vec_t M_READ      = 41'd1 << 24;
    localparam vec_t M_WRITE     = 41'd1 << 25;
    localparam vec_t M_INCPC     = 41'd1 << 26;
    localparam vec_t M_ADD       = 41'd1 << 27;
    localparam vec_t M_SUB       = 41'd1 << 28;
    localparam vec_t M_AND       = 41'd1 << 29;
    localparam vec_t M_OR        = 41'd1 << 30;
    localparam vec_t M_SHR       = 41'd1 << 31;
    localparam vec_t M_SHRA      = 41'd1 << 32;
    localparam vec_t M_SHL       = 41'd1 << 33;
    localparam vec_t M_ROR       = 41'd1 << 34;
    localparam vec_t M_ROL       = 41'd1 << 35;
    localparam vec_t M_MUL       = 41'd1 << 36;
    localparam vec_t M_DIV       = 41'd1 << 37;
    localparam vec_t M_NEG       = 41'd1 << 38;
    localparam vec_t M_NOT       = 41'd1 << 39;
    localparam vec_t M_RUN       = 41'd1 << 40;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        BranchOut;
    logic        Stop;
    logic        Run;
    logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout;
    logic        InPortout, Cout, BAout, Rout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin;
    logic        Rin, CONin, OutPortIn;
    logic        Gra, Grb, Grc;
    logic        Read, Write, IncPC;
    logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL;
    logic        MUL, DIV, NEG, NOT;

    vec_t        act_vec;
    vec_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 Clock = ~Clock;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .BranchOut(BranchOut),
        .Stop(Stop), .Run(Run),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .MDRout(MDRout), .LOout(LOout), .HIout(HIout),
        .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zin(Zin), .LOin(LOin), .HIin(HIin), .Rin(Rin),
        .CONin(CONin), .OutPortIn(OutPortIn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Read(Read), .Write(Write), .IncPC(IncPC),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA),
        .SHL(SHL), .ROR(ROR), .ROL(ROL), .MUL(MUL), .DIV(DIV),
        .NEG(NEG), .NOT(NOT)
    );

    assign act_vec = {Run, NOT, NEG, DIV, MUL, ROL, ROR, SHL, SHRA, SHR, OR,
                      AND, SUB, ADD, IncPC, Write, Read, Grc, Grb, Gra,
                      OutPortIn, CONin, Rin, HIin, LOin, Zin, Yin, MDRin,
                      MARin, IRin, PCin, Rout, BAout, Cout, InPortout, HIout,
                      LOout, MDRout, Zhighout, Zlowout, PCout};

    // ALU strobe named by each opcode's mnemonic.
    function automatic vec_t alu_for(input logic [4:0] op);
        case (op)
            5'b00011, 5'b01100: return M_ADD;
            5'b00100:           return M_SUB;
            5'b00101, 5'b01101: return M_AND;
            5'b00110, 5'b01110: return M_OR;
            5'b00111:           return M_ROR;
            5'b01000:           return M_ROL;
            5'b01001:           return M_SHR;
            5'b01010:           return M_SHRA;
            5'b01011:           return M_SHL;
            5'b01111:           return M_DIV;
            5'b10000:           return M_MUL;
            5'b10001:           return M_NEG;
            5'b10010:           return M_NOT;
            default:            return '0;
        endcase
    endfunction

    // Microprogram table: one entry per executed step, Run high throughout.
    task automatic build_program(input logic [4:0] op, input logic br_cond,
                                 output vec_q_t prog);
        vec_t a;
        a = alu_for(op);
        prog = {};
        prog.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
        prog.push_back(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN);
        prog.push_back(M_MDROUT | M_IRIN);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
            5'b01001, 5'b01010, 5'b01011: begin
                prog.push_back(M_GRB | M_ROUT | M_YIN);
                prog.push_back(M_GRC | M_ROUT | a | M_ZIN);
                prog.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                prog.push_back(M_GRB | M_ROUT | M_YIN);
                prog.push_back(M_COUT | a | M_ZIN);
                prog.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
            5'b00001: begin
                prog.push_back(M_GRB | M_BAOUT | M_YIN);
                prog.push_back(M_COUT | M_ADD | M_ZIN);
                prog.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
            5'b00000: begin
                prog.push_back(M_GRB | M_BAOUT | M_YIN);
                prog.push_back(M_COUT | M_ADD | M_ZIN);
                prog.push_back(M_ZLOWOUT | M_MARIN);
                prog.push_back(M_READ | M_MDRIN);
                prog.push_back(M_MDROUT | M_GRA | M_RIN);
            end
            5'b00010: begin
                prog.push_back(M_GRB | M_BAOUT | M_YIN);
                prog.push_back(M_COUT | M_ADD | M_ZIN);
                prog.push_back(M_ZLOWOUT | M_MARIN);
                prog.push_back(M_GRA | M_ROUT | M_WRITE);
            end
            5'b01111, 5'b10000: begin
                prog.push_back(M_GRA | M_ROUT | M_YIN);
                prog.push_back(M_GRB | M_ROUT | a | M_ZIN);
                prog.push_back(M_ZLOWOUT | M_LOIN);
                prog.push_back(M_ZHIGHOUT | M_HIIN);
            end
            5'b10001, 5'b10010: begin
                prog.push_back(M_GRB | M_ROUT | a | M_ZIN);
                prog.push_back(M_ZLOWOUT | M_GRA | M_RIN);
            end
            5'b10011: begin
                prog.push_back(M_GRA | M_ROUT | M_CONIN);
                prog.push_back(M_PCOUT | M_YIN);
                prog.push_back(M_COUT | M_ADD | M_ZIN);
                prog.push_back(M_ZLOWOUT | (br_cond ? M_PCIN : '0));
            end
            5'b10100: prog.push_back(M_GRA | M_ROUT | M_PCIN);
            5'b10101: begin
                prog.push_back(M_PCOUT | M_GRB | M_RIN);
                prog.push_back(M_GRA | M_ROUT | M_PCIN);
            end
            5'b10110: prog.push_back(M_INPORTOUT | M_GRA | M_RIN);
            5'b10111: prog.push_back(M_GRA | M_ROUT | M_OUTPORTIN);
            5'b11000: prog.push_back(M_HIOUT | M_GRA | M_RIN);
            5'b11001: prog.push_back(M_LOOUT | M_GRA | M_RIN);
            default: ;
        endcase
        foreach (prog[i]) prog[i] = prog[i] | M_RUN;
    endtask

    task automatic wait_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_output(input string name, input vec_t actual,
                                input vec_t expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Monitor: every sampled cycle consumes one scoreboard entry.
    always @(negedge Clock) begin : monitor
        vec_t expected;
        if (exp_q.size() > 0) begin
            expected = exp_q.pop_front();
            check_output("outputs", act_vec, expected);
            n_checks++;
            if ($countones(act_vec[9:0]) > 1) begin
                n_fail++;
                $display("[TB] FAIL bus_drivers: got %0d active required at most 1 (t=%0t)",
                         $countones(act_vec[9:0]), $time);
            end
        end
    end

    // Two cycles in reset, then release; returns in the first T0 cycle.
    task automatic do_reset();
        exp_q.push_back('0);
        Clear = 1'b0;
        wait_cycle();
        exp_q.push_back('0);
        Clear = 1'b1;
        wait_cycle();
    endtask

    // Entered during T0; returns in the cycle after the instruction's last
    // step (next T0, or HALT).
    task automatic apply_stimulus(input logic [31:0] ir, input logic br_cond,
                                  input logic stop_req, output bit halted);
        vec_q_t prog;
        IR = ir;
        BranchOut = br_cond;
        Stop = stop_req;
        build_program(ir[31:27], br_cond, prog);
        foreach (prog[i]) exp_q.push_back(prog[i]);
        repeat (prog.size()) wait_cycle();
        halted = (ir[31:27] == 5'b11011) || stop_req;
    endtask

    task automatic hold_halt(input int n);
        repeat (n) exp_q.push_back('0);
        repeat (n) wait_cycle();
    endtask

    initial begin : stimulus
        bit     halted;
        vec_q_t prog;
        logic [4:0] op;
        Clear = 1'b0;
        IR = '0;
        BranchOut = 1'b0;
        Stop = 1'b0;
        wait_cycle();
        do_reset();

        apply_stimulus(32'h19890000, 1'b0, 1'b0, halted);
        apply_stimulus(32'h98000000, 1'b0, 1'b0, halted);
        apply_stimulus(32'h98000000, 1'b1, 1'b0, halted);
        apply_stimulus(32'h00000000, 1'b0, 1'b0, halted);

        apply_stimulus(32'hD8000000, 1'b0, 1'b0, halted);
        hold_halt(20);
        do_reset();

        apply_stimulus(32'h80000000, 1'b0, 1'b1, halted);
        hold_halt(3);
        do_reset();

        // st interrupted by Clear in T5: outputs must drop in that cycle.
        IR = 32'h10000000;
        Stop = 1'b0;
        build_program(5'b00010, 1'b0, prog);
        for (int i = 0; i < 5; i++) exp_q.push_back(prog[i]);
        repeat (5) wait_cycle();
        do_reset();

        for (int k = 0; k < 40; k++) begin
            op = 5'($urandom_range(0, 31));
            apply_stimulus({op, 27'($urandom)}, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 7) == 0), halted);
            if (halted) begin
                hold_halt($urandom_range(1, 4));
                do_reset();
            end
        end

        wait_cycle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left required 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
